// File: rtl/i281_pkg.sv
// rtl/i281_pkg.sv - shared i281 control-FSM codes, opcodes and run-controller states
package i281_pkg;

   // Control-FSM state codes; IF is the instruction boundary
   localparam logic [4:0] ST_IF        = 5'd0;
   localparam logic [4:0] ST_ID        = 5'd1;
   localparam logic [4:0] ST_EX_ALU    = 5'd2;
   localparam logic [4:0] ST_WB_ALU    = 5'd3;
   localparam logic [4:0] ST_EX_ALUI   = 5'd4;
   localparam logic [4:0] ST_WB_ALUI   = 5'd5;
   localparam logic [4:0] ST_EX_ADDR   = 5'd6;
   localparam logic [4:0] ST_MEM_READ  = 5'd7;
   localparam logic [4:0] ST_WB_LOAD   = 5'd8;
   localparam logic [4:0] ST_EX_ADDRF  = 5'd9;
   localparam logic [4:0] ST_MEM_WRITE = 5'd10;
   localparam logic [4:0] ST_EX_LOADI  = 5'd11;
   localparam logic [4:0] ST_EX_MOVE   = 5'd12;
   localparam logic [4:0] ST_EX_SHIFT  = 5'd13;
   localparam logic [4:0] ST_EX_CMP    = 5'd14;
   localparam logic [4:0] ST_EX_JUMP   = 5'd15;
   localparam logic [4:0] ST_EX_BRANCH = 5'd16;
   localparam logic [4:0] ST_EX_INPUT  = 5'd17;
   localparam logic [4:0] ST_EX_NOOP   = 5'd18;
   localparam logic [4:0] ST_LR        = 5'd19;

   localparam logic [3:0] OP_NOOP   = 4'h0;
   localparam logic [3:0] OP_INPUTC = 4'h1;
   localparam logic [3:0] OP_MOVE   = 4'h2;
   localparam logic [3:0] OP_LOADI  = 4'h3;
   localparam logic [3:0] OP_ADD    = 4'h4;
   localparam logic [3:0] OP_ADDI   = 4'h5;
   localparam logic [3:0] OP_SUB    = 4'h6;
   localparam logic [3:0] OP_SUBI   = 4'h7;
   localparam logic [3:0] OP_LOAD   = 4'h8;
   localparam logic [3:0] OP_LOADF  = 4'h9;
   localparam logic [3:0] OP_STORE  = 4'hA;
   localparam logic [3:0] OP_STOREF = 4'hB;
   localparam logic [3:0] OP_SHIFT  = 4'hC;
   localparam logic [3:0] OP_CMP    = 4'hD;
   localparam logic [3:0] OP_JUMP   = 4'hE;
   localparam logic [3:0] OP_BRANCH = 4'hF;

   typedef enum logic [2:0] {
      CTRL_IDLE  = 3'd0,
      CTRL_RUN   = 3'd1,
      CTRL_STEP  = 3'd2,
      CTRL_BREAK = 3'd3,
      CTRL_DONE  = 3'd4
   } ctrl_state_e;

endpackage

// File: rtl/i281_sat_counter.sv
// rtl/i281_sat_counter.sv - enabled up-counter with synchronous clear that holds at all-ones
module i281_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/i281_run_controller.sv
// rtl/i281_run_controller.sv - run/step/breakpoint/watchdog sequencer producing the core advance enable
module i281_run_controller
   import i281_pkg::*;
#(
   parameter int               PC_W       = 6,
   parameter int               STATE_W    = 5,
   parameter int               CNT_W      = 16,
   parameter logic [CNT_W-1:0] MAX_CYCLES = 16'd50000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic               step,
   input  logic               bp_en,
   input  logic [PC_W-1:0]    bp_addr,
   input  logic [PC_W-1:0]    pc,
   input  logic [STATE_W-1:0] cpu_state,
   output logic               cpu_en,
   output logic [2:0]         ctrl_state,
   output logic               at_break,
   output logic               timeout,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [CNT_W-1:0]   instr_count
);

   localparam logic [CNT_W-1:0] WD_LAST = MAX_CYCLES - 1'b1;
   localparam bit               WD_ON   = (MAX_CYCLES != '0);

   ctrl_state_e state_q, state_d;
   logic        skip_bp_q, skip_bp_d;
   logic        first_if_q, first_if_d;
   logic        at_break_q, at_break_d;
   logic        timeout_q, timeout_d;
   logic        bnd, bp_hit, wd_fire;

   assign bnd    = (cpu_state == STATE_W'(ST_IF));
   assign bp_hit = bp_en && bnd && (pc == bp_addr) && !skip_bp_q;

   always_comb begin
      cpu_en     = 1'b0;
      wd_fire    = 1'b0;
      state_d    = state_q;
      skip_bp_d  = skip_bp_q;
      first_if_d = first_if_q;
      case (state_q)
         CTRL_IDLE: begin
            if (run) begin
               state_d   = CTRL_RUN;
               skip_bp_d = 1'b1;
            end else if (step) begin
               state_d    = CTRL_STEP;
               skip_bp_d  = 1'b1;
               first_if_d = 1'b0;
            end
         end
         CTRL_RUN: begin
            // run is only honoured at an instruction boundary
            cpu_en = !(bnd && (bp_hit || !run));
            if (bp_hit) begin
               state_d = CTRL_BREAK;
            end else if (bnd && !run) begin
               state_d = CTRL_IDLE;
            end
         end
         CTRL_STEP: begin
            cpu_en = !(bnd && first_if_q);
            if (bnd && first_if_q) begin
               state_d = CTRL_IDLE;
            end else if (bnd) begin
               first_if_d = 1'b1;
            end
         end
         CTRL_BREAK: begin
            if (step) begin
               state_d    = CTRL_STEP;
               skip_bp_d  = 1'b1;
               first_if_d = 1'b0;
            end else if (!run) begin
               state_d = CTRL_IDLE;
            end
         end
         CTRL_DONE: begin
            state_d = CTRL_DONE;
         end
         default: begin
            state_d = CTRL_IDLE;
         end
      endcase

      // the instruction sitting under a breakpoint runs once on resume
      if (cpu_en && bnd) begin
         skip_bp_d = 1'b0;
      end

      wd_fire = WD_ON && cpu_en && (cycle_count == WD_LAST);
      if (wd_fire) begin
         state_d = CTRL_DONE;
      end

      at_break_d = (state_d == CTRL_BREAK);
      timeout_d  = (state_d == CTRL_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= CTRL_IDLE;
         skip_bp_q  <= 1'b0;
         first_if_q <= 1'b0;
         at_break_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         skip_bp_q  <= skip_bp_d;
         first_if_q <= first_if_d;
         at_break_q <= at_break_d;
         timeout_q  <= timeout_d;
      end
   end

   i281_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clock (clock),
      .clr   (reset),
      .en    (cpu_en),
      .count (cycle_count)
   );

   i281_sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
      .clock (clock),
      .clr   (reset),
      .en    (cpu_en && bnd),
      .count (instr_count)
   );

   assign ctrl_state = state_q;
   assign at_break   = at_break_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_i281_run_controller.sv
// tb/tb_i281_run_controller.sv - bench for i281_run_controller with a toy multicycle core
module tb_i281_run_controller;
   import i281_pkg::*;

   localparam int MAXC = 40;
   localparam int CMAX = 65535;
   localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_BREAK = 3, M_DONE = 4;
   localparam int K_NOOP = 0, K_ADD = 1, K_LOAD = 2, K_JUMP = 3;

   logic        clock = 1'b0;
   logic        reset, run, step, bp_en;
   logic [5:0]  bp_addr, pc;
   logic [4:0]  cpu_state;
   logic        cpu_en, at_break, timeout;
   logic [2:0]  ctrl_state;
   logic [15:0] cycle_count, instr_count;

   i281_run_controller #(
      .PC_W(6), .STATE_W(5), .CNT_W(16), .MAX_CYCLES(16'd40)
   ) dut (
      .clock(clock), .reset(reset), .run(run), .step(step),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_state(cpu_state),
      .cpu_en(cpu_en), .ctrl_state(ctrl_state), .at_break(at_break),
      .timeout(timeout), .cycle_count(cycle_count), .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   // program: ADD, 5x NOOP, LOAD, ADD, LOAD, then JUMP-to-self at 9
   int prog [0:9] = '{K_ADD, K_NOOP, K_NOOP, K_NOOP, K_NOOP, K_NOOP, K_LOAD, K_ADD, K_LOAD, K_JUMP};
   int c_pc, c_k;

   int m_mode, n_mode, m_cyc, n_cyc, m_ins, n_ins;
   bit m_skip, n_skip, m_first, n_first;
   bit e_en, rst_pre, en_seen;
   int errors = 0, checks = 0, en_cnt = 0;

   function automatic int ilen(input int kind);
      case (kind)
         K_ADD:   return 4;
         K_LOAD:  return 5;
         default: return 3;
      endcase
   endfunction

   function automatic logic [4:0] cstate(input int kind, input int k);
      if (k == 0) return ST_IF;
      if (k == 1) return ST_ID;
      case (kind)
         K_ADD:   return (k == 2) ? ST_EX_ALU : ST_WB_ALU;
         K_LOAD:  return (k == 2) ? ST_EX_ADDR : ((k == 3) ? ST_MEM_READ : ST_WB_LOAD);
         K_JUMP:  return ST_EX_JUMP;
         default: return ST_EX_NOOP;
      endcase
   endfunction

   task automatic drive_core();
      pc        = 6'(c_pc);
      cpu_state = cstate(prog[c_pc], c_k);
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: derive this cycle's enable and next controller view from the rules
   task automatic eval_model();
      bit bnd, hit;
      bnd = (c_k == 0);
      hit = bp_en && bnd && (c_pc == int'(bp_addr)) && !m_skip;
      n_mode = m_mode; n_skip = m_skip; n_first = m_first; e_en = 0;
      if (m_mode == M_IDLE) begin
         if (run)       begin n_mode = M_RUN;  n_skip = 1; end
         else if (step) begin n_mode = M_STEP; n_skip = 1; n_first = 0; end
      end else if (m_mode == M_RUN) begin
         e_en = !(bnd && (hit || !run));
         if (hit)              n_mode = M_BREAK;
         else if (bnd && !run) n_mode = M_IDLE;
      end else if (m_mode == M_STEP) begin
         e_en = !(bnd && m_first);
         if (!e_en)    n_mode = M_IDLE;
         else if (bnd) n_first = 1;
      end else if (m_mode == M_BREAK) begin
         if (step)      begin n_mode = M_STEP; n_skip = 1; n_first = 0; end
         else if (!run) n_mode = M_IDLE;
      end
      if (e_en && bnd) n_skip = 0;
      if (e_en && m_cyc == MAXC - 1) n_mode = M_DONE;
      n_cyc = m_cyc + ((e_en && m_cyc < CMAX) ? 1 : 0);
      n_ins = m_ins + ((e_en && bnd && m_ins < CMAX) ? 1 : 0);
      if (reset) begin
         n_mode = M_IDLE; n_skip = 0; n_first = 0; n_cyc = 0; n_ins = 0;
      end
      rst_pre = reset;
      en_seen = (cpu_en === 1'b1);
      if (en_seen) en_cnt++;
   endtask

   task automatic check_outputs();
      check("cpu_en",      int'(cpu_en),      int'(e_en));
      check("ctrl_state",  int'(ctrl_state),  m_mode);
      check("at_break",    int'(at_break),    int'(m_mode == M_BREAK));
      check("timeout",     int'(timeout),     int'(m_mode == M_DONE));
      check("cycle_count", int'(cycle_count), m_cyc);
      check("instr_count", int'(instr_count), m_ins);
   endtask

   task automatic tick(input logic rst, input logic r, input logic s);
      @(posedge clock);
      #1;
      m_mode = n_mode; m_skip = n_skip; m_first = n_first; m_cyc = n_cyc; m_ins = n_ins;
      if (rst_pre) begin
         c_pc = 0; c_k = 0;
      end else if (en_seen) begin
         c_k++;
         if (c_k == ilen(prog[c_pc])) begin
            c_k  = 0;
            c_pc = (prog[c_pc] == K_JUMP) ? 9 : c_pc + 1;
         end
      end
      drive_core();
      reset = rst; run = r; step = s;
      @(negedge clock);
      eval_model();
      check_outputs();
   endtask

   task automatic reset_dut(input logic be, input logic [5:0] ba);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      bp_en = be; bp_addr = ba;
      tick(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic r;
      reset = 1'b1; run = 1'b0; step = 1'b0; bp_en = 1'b0; bp_addr = '0;
      c_pc = 0; c_k = 0; drive_core();
      m_mode = M_IDLE; m_skip = 0; m_first = 0; m_cyc = 0; m_ins = 0;
      @(negedge clock);
      eval_model();

      // reset then idle
      reset_dut(1'b0, 6'd0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
      check("idle_state", int'(ctrl_state), 0);
      check("idle_cycles", int'(cycle_count), 0);

      // single step of an ADD
      en_cnt = 0;
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0);
      check("step_en_cycles", en_cnt, 4);
      check("step_instr", int'(instr_count), 1);
      check("step_pc", int'(pc), 1);
      check("step_state", int'(ctrl_state), 0);

      // breakpoint at 5, then step over it
      reset_dut(1'b1, 6'd5);
      for (int i = 0; i < 40 && at_break !== 1'b1; i++) tick(1'b0, 1'b1, 1'b0);
      check("bp_at_break", int'(at_break), 1);
      check("bp_pc", int'(pc), 5);
      check("bp_en_low", int'(cpu_en), 0);
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         if (ctrl_state == 3'd0) break;
      end
      check("bp_resume_pc", int'(pc), 6);
      check("bp_resume_state", int'(ctrl_state), 0);
      check("bp_resume_cycles", int'(cycle_count), 19);

      // drop run during ExADDR of the LOAD at 6
      reset_dut(1'b0, 6'd0);
      for (int i = 0; i < 40 && !(c_pc == 6 && c_k == 1); i++) tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         if (ctrl_state == 3'd0) break;
      end
      check("rundrop_pc", int'(pc), 7);
      check("rundrop_at_if", int'(cpu_state), int'(ST_IF));
      check("rundrop_instr", int'(instr_count), 7);
      check("rundrop_cycles", int'(cycle_count), 24);

      // watchdog on the JUMP loop
      reset_dut(1'b0, 6'd0);
      for (int i = 0; i < 60 && timeout !== 1'b1; i++) tick(1'b0, 1'b1, 1'b0);
      check("wd_timeout", int'(timeout), 1);
      check("wd_cycles", int'(cycle_count), MAXC);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("wd_sticky", int'(ctrl_state), 4);

      // reset mid-STEP with run+step high, then run+step together from IDLE
      reset_dut(1'b0, 6'd0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      check("rst_mid_state", int'(ctrl_state), 0);
      check("rst_mid_cycles", int'(cycle_count), 0);
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b0);
      check("run_prio", int'(ctrl_state), 1);

      // randomized episodes against the reference
      for (int ep = 0; ep < 8; ep++) begin
         reset_dut(1'($urandom_range(0, 1)), 6'($urandom_range(0, 9)));
         r = 1'($urandom_range(0, 1));
         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) r = !r;
            tick(1'b0, r, 1'($urandom_range(0, 7) == 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_time bench did not finish");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/i281_run_controller.md
Name: i281_run_controller

Overview:
- Execution sequencer for the i281 multicycle core.
- Produces the single enable (cpu_en) that lets the control FSM, PC and register file advance.
- Implements free-run, single-instruction step, a PC breakpoint and a cycle-limit watchdog.
- Sits between the toplevel run/step inputs and the control logic; also counts cycles and retired instructions for the bench and the display.

Parameters:
- PC_W, 6, program counter width.
- STATE_W, 5, width of the control-FSM state code (IF = 0).
- CNT_W, 16, width of the cycle and instruction counters.
- MAX_CYCLES, 16'd50000, cpu_en cycles before the watchdog stops the core; 0 disables the watchdog.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; all registers load reset values on the next rising edge.
- run  in  1  level; 1 = free-run request.
- step  in  1  one-cycle pulse; requests execution of exactly one instruction.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- pc  in  PC_W  current core PC.
- cpu_state  in  STATE_W  current control-FSM state code.
- cpu_en  out  1  core advance enable (Mealy output, combinational from ctrl state and inputs).
- ctrl_state  out  3  encoded controller state.
- at_break  out  1  1 while in BREAK.
- timeout  out  1  1 while in DONE.
- cycle_count  out  CNT_W  number of cycles with cpu_en = 1.
- instr_count  out  CNT_W  number of instructions started (cycles with cpu_en = 1 and cpu_state = IF).

Behaviour:
- States: IDLE = 0, RUN = 1, STEP = 2, BREAK = 3, DONE = 4.
- Reset values: ctrl_state = IDLE, cpu_en = 0, at_break = 0, timeout = 0, both counters = 0, skip_bp = 0.
- Reset asserted mid-operation wins over every other event, including step and run.
- Instruction boundary (bnd): cpu_state == IF.
- Break hit (bp_hit): bp_en & bnd & (pc == bp_addr) & !skip_bp.

State actions:
- IDLE: cpu_en = 0.
  - run = 1 → RUN, skip_bp <= 1.
  - Otherwise step = 1 → STEP, skip_bp <= 1.
  - run takes priority when run and step are both high.
- RUN: cpu_en = !(bnd & (bp_hit | !run)).
  - bp_hit → BREAK, with cpu_en = 0 that cycle.
  - bnd & !run → IDLE, so the core pauses at IF; run is honoured only at boundaries.
  - step is ignored.
- STEP: first_if flag set on the first enabled IF cycle.
  - cpu_en = !(bnd & first_if): the core executes the whole instruction and pauses at the next IF.
  - Pause → IDLE.
  - Breakpoints are not checked in STEP.
- BREAK: cpu_en = 0, at_break = 1.
  - step → STEP, skip_bp <= 1.
  - run = 0 → IDLE.
  - Re-running from BREAK requires run to be low for at least one cycle (passing through IDLE).
- DONE: cpu_en = 0, timeout = 1. Left only by reset.

skip_bp:
- Cleared on the first cycle with cpu_en & bnd, so the instruction under a breakpoint executes once on resume.

Counters:
- cycle_count += 1 every cpu_en cycle.
- instr_count += 1 on cpu_en & bnd.
- Both saturate at all-ones (no wrap).

Watchdog:
- If MAX_CYCLES != 0 and cycle_count == MAX_CYCLES - 1 in a cpu_en cycle, go to DONE on that edge.
- DONE takes precedence over a simultaneous bp_hit or pause transition.

Latency:
- run/step are sampled on a rising edge; cpu_en rises in the cycle after that edge.

Decomposition:
- Shared package i281_pkg holds:
  - the control-FSM state codes (ST_IF = 0, ST_ID = 1, … ST_LR = 19);
  - the opcode constants already used by the control logic;
  - the controller state codes CTRL_IDLE … CTRL_DONE.
- One natural sub-module: i281_sat_counter (CNT_W, enable, synchronous clear, saturating), instantiated twice.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles, run = step = 0 → cpu_en = 0, ctrl_state = 0, counters = 0 for 10 cycles.
- Single step: core at IF, ID → ExALU → WbALU ADD; pulse step → cpu_en = 1 for exactly 4 cycles, instr_count = 1, ctrl_state returns to 0, cpu_state = IF.
- Breakpoint: bp_en = 1, bp_addr = 5, run = 1 → cpu_en = 0 when pc = 5 at IF, at_break = 1; step → instruction at 5 executes, pc = 6, ctrl_state = IDLE.
- Run deassert mid-instruction: drop run during ExADDR of a LOAD → core finishes MemREAD/WbLOAD, stops at next IF, ctrl_state = IDLE.
- Watchdog: MAX_CYCLES = 20, run = 1 with an infinite JUMP loop → cycle_count = 20, timeout = 1, cpu_en = 0; run/step toggles ignored until reset.
- Reset mid-STEP and run + step simultaneous in IDLE: reset → all values as at reset next edge; simultaneous run = step = 1 → ctrl_state = RUN.
